// File: rtl/hop_param_ctrl.sv
// Hop-kernel input sequencer: captures a hop request, runs the serial F/F' mod
// engine, presents kernel inputs for one settle cycle and latches the returned channel.
module hop_param_ctrl #(
  parameter int unsigned MODBITS = 26,
  parameter int unsigned NMIN    = 20,
  parameter int unsigned NMAX    = 79
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        req,
  output logic        ready,
  input  logic [1:0]  mode,
  input  logic [27:0] clk_in,
  input  logic [27:0] addr_in,
  input  logic [79:0] afh_map_in,
  input  logic [6:0]  afh_n_in,
  output logic [4:0]  k_X,
  output logic [4:0]  k_C,
  output logic [4:0]  k_A,
  output logic [3:0]  k_B,
  output logic [8:0]  k_D,
  output logic [6:0]  k_E,
  output logic [6:0]  k_F,
  output logic [6:0]  k_Fp,
  output logic        k_Y1,
  output logic [5:0]  k_Y2,
  output logic [79:0] k_map,
  output logic [6:0]  k_modN,
  input  logic [6:0]  k_fk,
  output logic [6:0]  fk,
  output logic        done,
  output logic        err
);

  localparam int unsigned CW = $clog2(MODBITS);

  typedef enum logic [1:0] {S_IDLE, S_MOD, S_SETTLE, S_DONE} state_e;

  typedef struct packed {
    logic [4:0]  x;
    logic        y1;
    logic [5:0]  y2;
    logic [4:0]  a;
    logic [3:0]  b;
    logic [4:0]  c;
    logic [8:0]  d;
    logic [6:0]  e;
    logic [6:0]  f;
    logic [6:0]  fp;
    logic [79:0] map;
    logic [6:0]  modn;
  } kset_t;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [27:1]    clk_q;
  logic [27:0]    addr_q;
  logic [79:0]    map_q;
  logic [6:0]     n_q;
  logic [1:0]     mode_q;
  logic [7:0]     r79_q, rN_q;
  logic [7:0]     r79_d, rN_d;
  kset_t          k_q;
  logic [6:0]     fk_q;
  logic           done_q, err_q, ready_q;

  logic [MODBITS-1:0] vbits;
  logic               b_bit;
  logic [6:0]         modn_eff;
  logic [8:0]         t79, tN;
  logic               last_iter;
  logic               unused_clk0;

  // CLK[0] plays no part in any kernel input.
  assign unused_clk0 = clk_in[0];

  function automatic kset_t build_k(input logic [1:0]  m,
                                    input logic [27:1] c,
                                    input logic [27:0] a,
                                    input logic [79:0] mp,
                                    input logic [6:0]  n,
                                    input logic [7:0]  f,
                                    input logic [7:0]  fp);
    kset_t k;
    k      = '0;
    k.b    = a[22:19];
    k.e    = {a[13], a[11], a[9], a[7], a[5], a[3], a[1]};
    k.map  = {1'b0, {79{1'b1}}};
    k.modn = 7'd79;
    if (m == 2'b00) begin
      k.x = c[16:12];
      k.a = a[27:23];
      k.c = {a[8], a[6], a[4], a[2], a[0]};
      k.d = a[18:10];
    end else begin
      k.x  = c[6:2];
      k.y1 = c[1];
      k.y2 = {c[1], 5'b00000};
      k.a  = a[27:23] ^ c[25:21];
      k.c  = {a[8], a[6], a[4], a[2], a[0]} ^ c[20:16];
      k.d  = a[18:10] ^ c[15:7];
      k.f  = 7'(f);
      k.fp = 7'(fp);
      if (m == 2'b10) begin
        k.map  = mp;
        k.modn = n;
      end
    end
    return k;
  endfunction

  // MSB-first walk over {CLK[27:7],5'b0}; F' sees all bits, F stops one short (x16 vs x32).
  always_comb begin
    vbits     = {clk_q[27:7], 5'b00000};
    b_bit     = vbits[CW'(MODBITS - 1) - cnt_q];
    last_iter = (cnt_q == CW'(MODBITS - 1));
    modn_eff  = (mode_q == 2'b10) ? n_q : 7'd79;
    t79       = {r79_q, b_bit};
    tN        = {rN_q, b_bit};
    r79_d     = (t79 >= 9'd79) ? 8'(t79 - 9'd79) : 8'(t79);
    rN_d      = (tN >= {2'b00, modn_eff}) ? 8'(tN - {2'b00, modn_eff}) : 8'(tN);
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      clk_q   <= '0;
      addr_q  <= '0;
      map_q   <= '0;
      n_q     <= '0;
      mode_q  <= '0;
      r79_q   <= '0;
      rN_q    <= '0;
      k_q     <= '0;
      fk_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            clk_q   <= clk_in[27:1];
            addr_q  <= addr_in;
            map_q   <= afh_map_in;
            n_q     <= afh_n_in;
            mode_q  <= mode;
            r79_q   <= '0;
            rN_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            if (mode == 2'b00) begin
              k_q     <= build_k(mode, clk_in[27:1], addr_in, afh_map_in, afh_n_in, '0, '0);
              state_q <= S_SETTLE;
            end else if ((mode == 2'b11) ||
                         ((mode == 2'b10) &&
                          ((afh_n_in < 7'(NMIN)) || (afh_n_in > 7'(NMAX))))) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_MOD;
            end
          end
        end
        S_MOD: begin
          rN_q <= rN_d;
          if (!last_iter) begin
            r79_q <= r79_d;
            cnt_q <= cnt_q + 1'b1;
          end else begin
            k_q     <= build_k(mode_q, clk_q, addr_q, map_q, n_q, r79_q, rN_d);
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          fk_q    <= k_fk;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign err    = err_q;
  assign fk     = fk_q;
  assign k_X    = k_q.x;
  assign k_Y1   = k_q.y1;
  assign k_Y2   = k_q.y2;
  assign k_A    = k_q.a;
  assign k_B    = k_q.b;
  assign k_C    = k_q.c;
  assign k_D    = k_q.d;
  assign k_E    = k_q.e;
  assign k_F    = k_q.f;
  assign k_Fp   = k_q.fp;
  assign k_map  = k_q.map;
  assign k_modN = k_q.modn;

endmodule
